// File: rtl/game_fsm.sv
// Console game-state controller: three button debouncers, press edge detection
// and the IDLE/PLAY/PAUSE/OVER/RESTART state machine driving stateGame.
module game_fsm #(
  parameter int unsigned         INTERVAL       = 20,
  parameter logic [INTERVAL-1:0] COUNTER_LIMITE = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resetFSM,
  input  logic       startGame,
  input  logic       pauseGame,
  input  logic       dead,
  output logic [2:0] stateGame,
  output logic       btn_reset,
  output logic       btn_start,
  output logic       btn_pause
);

  localparam int unsigned NumBtn   = 3;
  localparam int unsigned BtnReset = 0;
  localparam int unsigned BtnStart = 1;
  localparam int unsigned BtnPause = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPlay    = 3'd1,
    StPause   = 3'd2,
    StOver    = 3'd3,
    StRestart = 3'd4
  } state_e;

  logic [NumBtn-1:0]   raw;
  logic [NumBtn-1:0]   sync1_q, sync2_q;
  logic [NumBtn-1:0]   btn_q, btn_d;
  logic [NumBtn-1:0]   btn_prev_q;
  logic [NumBtn-1:0]   press;
  logic [INTERVAL-1:0] count_q [NumBtn];
  logic [INTERVAL-1:0] count_d [NumBtn];
  state_e              state_q, state_d;

  assign raw = {pauseGame, startGame, resetFSM};

  // Debounce next state: count cycles the synchronized input disagrees with the
  // accepted level; accept it once the count has reached the limit.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      btn_d[i]   = btn_q[i];
      count_d[i] = '0;
      if (sync2_q[i] != btn_q[i]) begin
        if (count_q[i] == COUNTER_LIMITE) begin
          btn_d[i] = sync2_q[i];
        end else begin
          count_d[i] = count_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchronizers, debounce counters, accepted levels and edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      btn_q      <= btn_d;
      btn_prev_q <= btn_q;
      for (int i = 0; i < NumBtn; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  // One-cycle press pulse on each rising edge of an accepted level.
  assign press = btn_q & ~btn_prev_q;

  // Next-state logic; the if-chains encode reset press > dead > pause > start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (press[BtnReset]) begin
          state_d = StRestart;
        end else if (press[BtnStart]) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (press[BtnReset]) begin
          state_d = StRestart;
        end else if (dead) begin
          state_d = StOver;
        end else if (press[BtnPause]) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (press[BtnReset]) begin
          state_d = StRestart;
        end else if (press[BtnPause] || press[BtnStart]) begin
          state_d = StPlay;
        end
      end
      StOver: begin
        if (press[BtnReset]) begin
          state_d = StRestart;
        end else if (press[BtnStart]) begin
          state_d = StPlay;
        end
      end
      StRestart: state_d = StIdle;
      // Unused codes recover to IDLE.
      default:   state_d = StIdle;
    endcase
  end

  // Game state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign stateGame = state_q;
  assign btn_reset = btn_q[BtnReset];
  assign btn_start = btn_q[BtnStart];
  assign btn_pause = btn_q[BtnPause];

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: directed scenarios plus random button/dead activity,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_game_fsm;

  localparam int Limit = 16;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       resetFSM  = 1'b0;
  logic       startGame = 1'b0;
  logic       pauseGame = 1'b0;
  logic       dead      = 1'b0;
  logic [2:0] stateGame;
  logic       btn_reset, btn_start, btn_pause;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       br;
    logic       bs;
    logic       bp;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: raw samples delayed two cycles, accepted levels,
  // previous accepted levels, run length of disagreement, game state code.
  int m_state;
  int m_d1[3], m_d2[3], m_btn[3], m_prev[3], m_run[3];

  game_fsm #(
    .INTERVAL      (5),
    .COUNTER_LIMITE(5'd16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .resetFSM (resetFSM),
    .startGame(startGame),
    .pauseGame(pauseGame),
    .dead     (dead),
    .stateGame(stateGame),
    .btn_reset(btn_reset),
    .btn_start(btn_start),
    .btn_pause(btn_pause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks_total++;
    if (act == req) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic void model_reset();
    m_state = 0;
    for (int i = 0; i < 3; i++) begin
      m_d1[i] = 0; m_d2[i] = 0; m_btn[i] = 0; m_prev[i] = 0; m_run[i] = 0;
    end
  endfunction

  // One clock edge: index 0 = resetFSM, 1 = startGame, 2 = pauseGame.
  function automatic void model_step(input int r0, input int r1, input int r2, input int dd);
    int raw[3];
    int pr[3];
    int nxt;
    raw = '{r0, r1, r2};
    for (int i = 0; i < 3; i++) pr[i] = (m_btn[i] != 0 && m_prev[i] == 0) ? 1 : 0;
    nxt = m_state;
    if (m_state >= 4) nxt = 0;
    else if (pr[0] != 0) nxt = 4;
    else if (m_state == 0 && pr[1] != 0) nxt = 1;
    else if (m_state == 1 && dd != 0) nxt = 3;
    else if (m_state == 1 && pr[2] != 0) nxt = 2;
    else if (m_state == 2 && (pr[1] != 0 || pr[2] != 0)) nxt = 1;
    else if (m_state == 3 && pr[1] != 0) nxt = 1;
    m_state = nxt;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = m_btn[i];
      // A level is accepted after Limit+1 consecutive disagreeing samples.
      if (m_d2[i] != m_btn[i]) begin
        m_run[i]++;
        if (m_run[i] == Limit + 1) begin
          m_btn[i] = m_d2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_d2[i] = m_d1[i];
      m_d1[i] = raw[i];
    end
  endfunction

  // Advance one edge, update the model with the inputs sampled there, queue the expectation.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else model_step(int'(resetFSM), int'(startGame), int'(pauseGame), int'(dead));
    e.st = m_state[2:0];
    e.br = (m_btn[0] != 0);
    e.bs = (m_btn[1] != 0);
    e.bp = (m_btn[2] != 0);
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Full press: 40 cycles held, 40 cycles released. idx as in the model.
  task automatic full_press(input int idx);
    if (idx == 0) resetFSM = 1'b1; else if (idx == 1) startGame = 1'b1; else pauseGame = 1'b1;
    cycles(40);
    if (idx == 0) resetFSM = 1'b0; else if (idx == 1) startGame = 1'b0; else pauseGame = 1'b0;
    cycles(40);
  endtask

  // Monitor: every cycle the DUT presents fresh outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", int'({stateGame, btn_reset, btn_start, btn_pause}), int'(e));
      end
    end
  end

  initial begin
    model_reset();
    #2 reset = 1'b0;
    cycles(3);
    check("reset_state", int'(stateGame), 0);
    check("reset_btns", int'({btn_reset, btn_start, btn_pause}), 0);
    @(negedge clk);
    #1 reset = 1'b1;
    cycles(4);

    // Start press: accepted at edge 19, PLAY at edge 20.
    startGame = 1'b1;
    cycles(18);
    check("btn_start_edge18", int'(btn_start), 0);
    cycle();
    check("btn_start_edge19", int'(btn_start), 1);
    check("state_edge19", int'(stateGame), 0);
    cycle();
    check("play_edge20", int'(stateGame), 1);
    cycles(20);
    startGame = 1'b0;
    cycles(40);

    // Short pause glitch is filtered.
    pauseGame = 1'b1;
    cycles(5);
    pauseGame = 1'b0;
    cycles(30);
    check("glitch_btn_pause", int'(btn_pause), 0);
    check("glitch_state", int'(stateGame), 1);
    full_press(2);
    check("pause_enter", int'(stateGame), 2);
    full_press(2);
    check("pause_resume", int'(stateGame), 1);

    // Dead for one cycle.
    dead = 1'b1;
    cycle();
    dead = 1'b0;
    check("dead_over", int'(stateGame), 3);
    full_press(1);
    check("over_restart_play", int'(stateGame), 1);

    // Reset press from PAUSE: RESTART for one cycle then IDLE, held button no re-entry.
    full_press(2);
    check("pause_again", int'(stateGame), 2);
    resetFSM = 1'b1;
    cycles(19);
    check("before_restart", int'(stateGame), 2);
    cycle();
    check("restart_state", int'(stateGame), 4);
    cycle();
    check("restart_to_idle", int'(stateGame), 0);
    cycles(30);
    check("held_reset_idle", int'(stateGame), 0);
    resetFSM = 1'b0;
    cycles(40);

    // Dead wins over a simultaneous pause press.
    full_press(1);
    pauseGame = 1'b1;
    cycles(19);
    dead = 1'b1;
    cycle();
    dead = 1'b0;
    check("dead_beats_pause", int'(stateGame), 3);
    cycles(20);
    pauseGame = 1'b0;
    cycles(40);

    // Reset press wins over simultaneous dead.
    full_press(1);
    resetFSM = 1'b1;
    cycles(19);
    dead = 1'b1;
    cycle();
    dead = 1'b0;
    check("reset_beats_dead", int'(stateGame), 4);
    cycles(20);
    resetFSM = 1'b0;
    cycles(40);

    // Async reset in PLAY while a start debounce is counting.
    full_press(1);
    startGame = 1'b1;
    cycles(8);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_state", int'(stateGame), 0);
    check("async_reset_btns", int'({btn_reset, btn_start, btn_pause}), 0);
    model_reset();
    cycles(2);
    @(negedge clk);
    #1 reset = 1'b1;
    cycles(18);
    check("counters_cleared", int'(btn_start), 0);
    cycle();
    check("new_press_accepted", int'(btn_start), 1);
    cycle();
    check("new_press_play", int'(stateGame), 1);
    startGame = 1'b0;
    cycles(40);

    // Random button toggles and dead pulses.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0:       resetFSM  = ~resetFSM;
          1:       startGame = ~startGame;
          default: pauseGame = ~pauseGame;
        endcase
      end
      dead = ($urandom_range(0, 19) == 0);
      cycle();
    end
    dead = 1'b0;

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
